spike_rx: RTL and testbench
===========================

SPIKE_RX -- requirements
Module: spike_rx

Interface
REQ-001 Parameter WIN_LEN, default 16: window length in clock cycles, minimum 2.
REQ-002 Parameter CNT_W, default 8: width of the spike counter.
REQ-003 Parameter T_W, default $clog2(WIN_LEN): width of the cycle index and first-spike time.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 win_start  input  1  single-cycle request to open a counting window.
REQ-007 in_valid  input  1  spike-stream qualifier from the neuron output stage.
REQ-008 in_spike  input  1  spike bit; meaningful only when in_valid=1.
REQ-009 busy  output  1  high while the block is in COUNT or HOLD.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 spike_cnt  output  CNT_W  number of spikes counted in the window.
REQ-013 first_t  output  T_W  cycle index (0..WIN_LEN-1) of the first counted spike.
REQ-014 first_seen  output  1  at least one spike was counted in the window.
REQ-015 ovf  output  1  spike count exceeded 2^CNT_W-1 during the window.

Function
REQ-016 FSM states: IDLE, COUNT, HOLD.
REQ-017 IDLE->COUNT on win_start=1; cycle index, spike_cnt, first_seen and ovf clear on this edge.
REQ-018 win_start is ignored in COUNT and HOLD.
REQ-019 In COUNT, a spike is counted in any cycle with in_valid=1 and in_spike=1; in_spike is ignored when in_valid=0.
REQ-020 Window cycle 0 is the first cycle spent in COUNT; the window spans exactly WIN_LEN cycles.
REQ-021 A spike on the last cycle (index WIN_LEN-1) is counted.
REQ-022 COUNT->HOLD on the edge ending cycle WIN_LEN-1.
REQ-023 On the first counted spike, first_t captures the cycle index and first_seen sets; later spikes do not change first_t.
REQ-024 first_t reads 0 when first_seen=0.
REQ-025 res_valid=1 exactly while in HOLD (registered output).
REQ-026 spike_cnt, first_t, first_seen and ovf are stable throughout HOLD.
REQ-027 HOLD->IDLE on the edge where res_valid=1 and res_ready=1.
REQ-028 Latency from win_start to res_valid is WIN_LEN+1 cycles.
REQ-029 If res_ready is already high on entry to HOLD, res_valid is high for exactly one cycle.
REQ-030 win_start asserted in the handshake cycle is ignored; a new window needs win_start while in IDLE.
REQ-031 res_ready outside HOLD has no effect.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 With rst=0, the block enters IDLE immediately, asynchronously, including mid-window or in HOLD.
REQ-034 Reset clears busy, res_valid, spike_cnt, first_t, first_seen and ovf to 0; an interrupted window produces no result.
REQ-035 Reset deassertion is synchronous to clk; the first win_start is accepted on the first rising edge after rst goes high.

Configuration
REQ-036 Macro SPIKE_RX_SAT_EN controls counter overflow behaviour.
REQ-037 With SPIKE_RX_SAT_EN defined, spike_cnt saturates at 2^CNT_W-1.
REQ-038 With SPIKE_RX_SAT_EN undefined, spike_cnt wraps modulo 2^CNT_W.
REQ-039 In both builds, ovf sets on the first count attempted at 2^CNT_W-1 and stays set until the next window or reset.

Verification
REQ-040 WIN_LEN=16: win_start, spikes at cycles 3, 7 and 15, res_ready=1 -> res_valid one cycle at cycle 17; spike_cnt=3, first_t=3, first_seen=1, ovf=0.
REQ-041 Window with in_valid=0 and in_spike=1 throughout -> spike_cnt=0, first_seen=0, first_t=0.
REQ-042 Backpressure: res_ready=0 for 5 cycles after HOLD entry -> outputs stable; returns to IDLE one edge after res_ready=1; win_start pulses during HOLD are ignored.
REQ-043 CNT_W=4, 16 consecutive spikes -> SAT build: spike_cnt=15, ovf=1; non-SAT build: spike_cnt=0, ovf=1.
REQ-044 rst=0 at window cycle 8 -> busy=0 and all outputs 0 immediately; after release, a new win_start yields a normal result with no residue.

Source files
------------

// File: rtl/spike_rx.sv
// rtl/spike_rx.sv - windowed spike counter with first-spike timestamp and result handshake
// Build macro SPIKE_RX_SAT_EN: saturating spike counter (default build wraps)
module spike_rx #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int T_W     = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_start,
  input  logic             in_valid,
  input  logic             in_spike,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] spike_cnt,
  output logic [T_W-1:0]   first_t,
  output logic             first_seen,
  output logic             ovf
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_COUNT  = 2'd1;
  localparam logic [1:0]       S_HOLD   = 2'd2;
  localparam logic [T_W-1:0]   LAST_IDX = T_W'(WIN_LEN - 1);
  localparam logic [T_W-1:0]   IDX_ONE  = T_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [T_W-1:0]   r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [T_W-1:0]   r_first_t;
  logic             r_first_seen;
  logic             r_ovf;
  logic             r_res_valid;

  logic w_hit;
  logic w_cnt_max;
  logic w_last;

  assign w_hit     = (r_state == S_COUNT) && in_valid && in_spike;
  assign w_cnt_max = &r_cnt;
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_first_t    <= '0;
      r_first_seen <= 1'b0;
      r_ovf        <= 1'b0;
      r_res_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (win_start) begin
            r_state      <= S_COUNT;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_first_t    <= '0;
            r_first_seen <= 1'b0;
            r_ovf        <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_hit) begin
            // A count attempted at full scale flags overflow in both builds
            if (w_cnt_max) begin
              r_ovf <= 1'b1;
`ifdef SPIKE_RX_SAT_EN
              r_cnt <= r_cnt;
`else
              r_cnt <= '0;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
            if (!r_first_seen) begin
              r_first_t    <= r_idx;
              r_first_seen <= 1'b1;
            end
          end
          if (w_last) begin
            r_state     <= S_HOLD;
            r_res_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign res_valid  = r_res_valid;
  assign spike_cnt  = r_cnt;
  assign first_t    = r_first_t;
  assign first_seen = r_first_seen;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_spike_rx.sv
// tb/tb_spike_rx.sv - self-checking bench for spike_rx (8-bit and 4-bit counter instances)
module tb_spike_rx;

  localparam int WIN_LEN = 16;
  localparam int T_W     = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic win_start = 1'b0;
  logic in_valid = 1'b0;
  logic in_spike = 1'b0;
  logic res_ready = 1'b0;

  logic           busy8, res_valid8, first_seen8, ovf8;
  logic [7:0]     spike_cnt8;
  logic [T_W-1:0] first_t8;
  logic           busy4, res_valid4, first_seen4, ovf4;
  logic [3:0]     spike_cnt4;
  logic [T_W-1:0] first_t4;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_n;
  int exp_first;
  bit exp_seen;

  always #5 clk = ~clk;

  spike_rx #(.WIN_LEN(WIN_LEN), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .win_start(win_start), .in_valid(in_valid), .in_spike(in_spike),
    .busy(busy8), .res_valid(res_valid8), .res_ready(res_ready), .spike_cnt(spike_cnt8),
    .first_t(first_t8), .first_seen(first_seen8), .ovf(ovf8)
  );

  spike_rx #(.WIN_LEN(WIN_LEN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .win_start(win_start), .in_valid(in_valid), .in_spike(in_spike),
    .busy(busy4), .res_valid(res_valid4), .res_ready(res_ready), .spike_cnt(spike_cnt4),
    .first_t(first_t4), .first_seen(first_seen4), .ovf(ovf4)
  );

  // Reference count for a window with n counted spikes on a w-bit counter
  function automatic int model_cnt(input int n, input int w);
    int max_v;
    max_v = (1 << w) - 1;
`ifdef SPIKE_RX_SAT_EN
    return (n > max_v) ? max_v : n;
`else
    return n % (1 << w);
`endif
  endfunction

  function automatic logic [13:0] exp8();
    return {8'(model_cnt(exp_n, 8)), 4'(exp_first), exp_seen, (exp_n > 255)};
  endfunction

  function automatic logic [9:0] exp4();
    return {4'(model_cnt(exp_n, 4)), 4'(exp_first), exp_seen, (exp_n > 15)};
  endfunction

  // Starts a window at the current (post-edge) time and plays WIN_LEN cycles; ends just after HOLD entry
  task automatic drive_window(input logic [15:0] vm, input logic [15:0] sm, input logic rr);
    res_ready = rr;
    win_start = 1'b1;
    @(posedge clk); #1;
    exp_n = 0; exp_first = 0; exp_seen = 1'b0;
    for (int i = 0; i < WIN_LEN; i++) begin
      in_valid  = vm[i];
      in_spike  = sm[i];
      win_start = 1'($urandom_range(0, 1));
      if (vm[i] && sm[i]) begin
        if (!exp_seen) exp_first = i;
        exp_seen = 1'b1;
        exp_n++;
      end
      n_checks++;
      if ({busy8, res_valid8, busy4, res_valid4} !== 4'b1010) begin
        n_fail++;
        $display("FAIL window_cycle%0d: busy/res_valid got %b want 1010", i, {busy8, res_valid8, busy4, res_valid4});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_spike = 1'b0; win_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset8: got %h want 0", {busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8});
    end
    n_checks++;
    if ({busy4, res_valid4, spike_cnt4, first_t4, first_seen4, ovf4} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset4: got %h want 0", {busy4, res_valid4, spike_cnt4, first_t4, first_seen4, ovf4});
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    drive_window(16'hFFFF, 16'h8088, 1'b1);
    n_checks++;
    if ({res_valid8, res_valid4} !== 2'b11) begin
      n_fail++;
      $display("FAIL basic_res_valid: got %b want 11", {res_valid8, res_valid4});
    end
    n_checks++;
    if ({spike_cnt8, first_t8, first_seen8, ovf8} !== {8'd3, 4'd3, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got %h want %h", {spike_cnt8, first_t8, first_seen8, ovf8}, {8'd3, 4'd3, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy8, res_valid8, busy4, res_valid4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_one_cycle: busy/res_valid got %b want 0000", {busy8, res_valid8, busy4, res_valid4});
    end
  endtask

  task automatic test_invalid_ignored();
    drive_window(16'h0000, 16'hFFFF, 1'b1);
    n_checks++;
    if ({res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== {1'b1, 14'h0}) begin
      n_fail++;
      $display("FAIL invalid_ignored: got %h want %h", {res_valid8, spike_cnt8, first_t8, first_seen8, ovf8}, {1'b1, 14'h0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int w = 0; w < 20; w++) begin
      logic [15:0] vm, sm;
      int hold;
      vm = 16'($urandom);
      sm = 16'($urandom);
      hold = (w % 2 == 0) ? 0 : $urandom_range(1, 3);
      drive_window(vm, sm, (hold == 0));
      for (int k = 0; k <= hold; k++) begin
        if (k == hold) res_ready = 1'b1;
        n_checks++;
        if ({res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== {1'b1, exp8()}) begin
          n_fail++;
          $display("FAIL random8 w%0d k%0d: got %h want %h", w, k, {res_valid8, spike_cnt8, first_t8, first_seen8, ovf8}, {1'b1, exp8()});
        end
        n_checks++;
        if ({res_valid4, spike_cnt4, first_t4, first_seen4, ovf4} !== {1'b1, exp4()}) begin
          n_fail++;
          $display("FAIL random4 w%0d k%0d: got %h want %h", w, k, {res_valid4, spike_cnt4, first_t4, first_seen4, ovf4}, {1'b1, exp4()});
        end
        @(posedge clk); #1;
      end
      n_checks++;
      if ({busy8, res_valid8} !== 2'b00) begin
        n_fail++;
        $display("FAIL random_idle w%0d: got %b want 00", w, {busy8, res_valid8});
      end
    end
  endtask

  task automatic test_backpressure();
    drive_window(16'($urandom), 16'($urandom), 1'b0);
    for (int k = 0; k < 5; k++) begin
      win_start = 1'(k % 2);
      n_checks++;
      if ({busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== {2'b11, exp8()}) begin
        n_fail++;
        $display("FAIL backpressure k%0d: got %h want %h", k, {busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8}, {2'b11, exp8()});
      end
      @(posedge clk); #1;
    end
    win_start = 1'b1;
    res_ready = 1'b1;
    n_checks++;
    if ({res_valid8, spike_cnt4, first_t4, first_seen4, ovf4} !== {1'b1, exp4()}) begin
      n_fail++;
      $display("FAIL backpressure_hs: got %h want %h", {res_valid8, spike_cnt4, first_t4, first_seen4, ovf4}, {1'b1, exp4()});
    end
    @(posedge clk); #1;
    win_start = 1'b0;
    n_checks++;
    if ({busy8, res_valid8, busy4, res_valid4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL backpressure_release: got %b want 0000", {busy8, res_valid8, busy4, res_valid4});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy8, busy4} !== 2'b00) begin
      n_fail++;
      $display("FAIL hs_win_start_ignored: busy got %b want 00", {busy8, busy4});
    end
  endtask

  task automatic test_overflow();
    logic [15:0] pats [2];
    pats[0] = 16'h7FFF;
    pats[1] = 16'hFFFF;
    for (int p = 0; p < 2; p++) begin
      drive_window(pats[p], pats[p], 1'b1);
      n_checks++;
      if ({spike_cnt4, first_t4, first_seen4, ovf4} !== exp4()) begin
        n_fail++;
        $display("FAIL overflow4 p%0d: got %h want %h", p, {spike_cnt4, first_t4, first_seen4, ovf4}, exp4());
      end
      n_checks++;
      if ({spike_cnt8, first_t8, first_seen8, ovf8} !== exp8()) begin
        n_fail++;
        $display("FAIL overflow8 p%0d: got %h want %h", p, {spike_cnt8, first_t8, first_seen8, ovf8}, exp8());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    win_start = 1'b1;
    @(posedge clk); #1;
    win_start = 1'b0;
    in_valid = 1'b1;
    in_spike = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid8: got %h want 0", {busy8, res_valid8, spike_cnt8, first_t8, first_seen8, ovf8});
    end
    n_checks++;
    if ({busy4, res_valid4, spike_cnt4, first_t4, first_seen4, ovf4} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_mid4: got %h want 0", {busy4, res_valid4, spike_cnt4, first_t4, first_seen4, ovf4});
    end
    in_valid = 1'b0;
    in_spike = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy8, res_valid8} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_no_result: got %b want 00", {busy8, res_valid8});
    end
    drive_window(16'hF0F0, 16'h3C3C, 1'b1);
    n_checks++;
    if ({res_valid8, spike_cnt8, first_t8, first_seen8, ovf8} !== {1'b1, exp8()}) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %h want %h", {res_valid8, spike_cnt8, first_t8, first_seen8, ovf8}, {1'b1, exp8()});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid_ignored();
    test_random();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
